// File: rtl/mult_arbiter_if.sv
// Requester and multiplier bus of mult_arbiter.
// The slave modport is the arbiter side; master is requesters plus multiplier.
interface mult_arbiter_if #(
  parameter int OP_SZ = 32,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*OP_SZ-1:0] req_a;
  logic [N_REQ*OP_SZ-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [OP_SZ-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic [3:0]             m_op;
  logic [OP_SZ-1:0]       m_mult0;
  logic [OP_SZ-1:0]       m_mult1;
  logic [OP_SZ-1:0]       m_out;
  logic                   m_op_done;

  modport slave (
    input  req, req_a, req_b, m_out, m_op_done,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, m_op, m_mult0, m_mult1
  );

  modport master (
    output req, req_a, req_b, m_out, m_op_done,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, m_op, m_mult0, m_mult1
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one shift-add multiplier among N_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT cycles.
module mult_arbiter #(
  parameter int OP_SZ   = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 40
) (
  input logic           clk,
  input logic           reset,
  mult_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd2;

  if (TIMEOUT <= OP_SZ + 1) begin : g_timeout_too_short
    $error("mult_arbiter: TIMEOUT must exceed OP_SZ+1");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("mult_arbiter: N_REQ must be in 2..8");
  end

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [OP_SZ-1:0] rsp_data_q, rsp_data_d;
  logic [OP_SZ-1:0] m_mult0_q, m_mult0_d;
  logic [OP_SZ-1:0] m_mult1_q, m_mult1_d;
  logic [3:0]       m_op_q, m_op_d;
  logic             busy_q, busy_d;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_s;
  logic [IDX_W-1:0] cand_s;
  logic [OP_SZ-1:0] sel_a_s;
  logic [OP_SZ-1:0] sel_b_s;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_s       = '0;
    cand_s       = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand_s       = IDX_W'((int'(rr_ptr_q) + off) % N_REQ);
      pick_valid_s = pick_valid_s | bus.req[cand_s];
      pick_s       = bus.req[cand_s] ? cand_s : pick_s;
    end
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s = (pick_s == IDX_W'(i)) ? bus.req_a[i*OP_SZ +: OP_SZ] : sel_a_s;
      sel_b_s = (pick_s == IDX_W'(i)) ? bus.req_b[i*OP_SZ +: OP_SZ] : sel_b_s;
    end
  end

  // Next-state and registered-output computation for IDLE/ISSUE/WAIT/RESP.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    m_mult0_d   = m_mult0_q;
    m_mult1_d   = m_mult1_q;
`ifdef MULT_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          win_d     = pick_s;
          rr_ptr_d  = (pick_s == IDX_W'(N_REQ - 1)) ? '0 : pick_s + IDX_W'(1);
          gnt_d     = one_hot(pick_s);
          m_mult0_d = sel_a_s;
          m_mult1_d = sel_b_s;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.m_op_done) begin
          rsp_data_d  = bus.m_out;
          rsp_valid_d = one_hot(win_q);
`ifdef MULT_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_valid_d = one_hot(win_q);
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
`endif
        else begin
`ifdef MULT_ARB_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
          state_d = ST_WAIT;
        end
      end
      // RESP doubles as the multiplier's post-done recovery cycle.
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    m_op_d = (state_d == ST_ISSUE) ? OP_MUL : OP_NONE;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      m_mult0_q   <= '0;
      m_mult1_q   <= '0;
      m_op_q      <= OP_NONE;
      busy_q      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      m_mult0_q   <= m_mult0_d;
      m_mult1_q   <= m_mult1_d;
      m_op_q      <= m_op_d;
      busy_q      <= busy_d;
`ifdef MULT_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.m_op      = m_op_q;
  assign bus.m_mult0   = m_mult0_q;
  assign bus.m_mult1   = m_mult1_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural shift-add multiplier
// whose active time is (bit length of operand 1) + 1 cycles.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mult_arbiter_if #(.OP_SZ(W), .N_REQ(N)) bus ();

  mult_arbiter #(.OP_SZ(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [2*N+4:0] obs;
  assign obs = {bus.gnt, bus.rsp_valid, bus.m_op, bus.busy};

  // Multiplier model: loads on m_op==2, pulses done on its last active cycle.
  int         mul_cnt;
  logic [W-1:0] mul_prod;
  logic       stub_dead;
  logic       extra_done;

  function automatic int kof(input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mul_cnt  <= 0;
      mul_prod <= '0;
    end else if (mul_cnt == 0 && bus.m_op == 4'd2) begin
      mul_cnt  <= kof(bus.m_mult1);
      mul_prod <= bus.m_mult0 * bus.m_mult1;
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
    end
  end

  assign bus.m_op_done = ((mul_cnt == 1) && !stub_dead) || extra_done;
  assign bus.m_out     = mul_prod;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({obs, bus.rsp_data, bus.rsp_err, bus.m_mult0, bus.m_mult1} !== '0)
      begin failures++; $display("FAIL reset_state obs=%h data=%h err=%b m0=%h m1=%h required all zero", obs, bus.rsp_data, bus.rsp_err, bus.m_mult0, bus.m_mult1); end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL idle_no_req obs=%h required 0", obs); end
  endtask

  // One isolated operation with a known multiplier latency k.
  task automatic test_single_op(input string name, input int idx, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int k, input logic [W-1:0] prod);
    logic [N-1:0]   oh;
    logic [2*N+4:0] exp;
    oh = '0;
    oh[idx] = 1'b1;
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
    bus.req[idx] = 1'b1;
    for (int t = 1; t <= k + 4; t++) begin
      step();
      exp = {(t == 1) ? oh : 4'b0000, (t == k + 2) ? oh : 4'b0000,
             (t == 1) ? 4'd2 : 4'd0, (t <= k + 2)};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL %s t=%0d obs=%h required %h", name, t, obs, exp); end
      if (t == k + 2) begin
        checks++;
        if ({bus.rsp_err, bus.rsp_data} !== {1'b0, prod})
          begin failures++; $display("FAIL %s_data err=%b data=%h required 0/%h", name, bus.rsp_err, bus.rsp_data, prod); end
      end
      if (t == 1) bus.req[idx] = 1'b0;
    end
  endtask

  task automatic test_stray_done();
    extra_done = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      extra_done = 1'b0;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL stray_done t=%0d obs=%h required 0", t, obs); end
    end
  endtask

  task automatic test_all_four();
    int gq[$];
    int rq[$];
    logic [W-1:0] dq[$];
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = W'(i + 1);
      bus.req_b[i*W +: W] = 32'd3;
    end
    bus.req = 4'b1111;
    for (int t = 0; t < 200 && rq.size() < N; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin gq.push_back(i); bus.req[i] = 1'b0; end
        if (bus.rsp_valid[i]) begin rq.push_back(i); dq.push_back(bus.rsp_data); end
      end
    end
    checks++;
    if (rq.size() != N || gq.size() != N)
      begin failures++; $display("FAIL all_four_count grants=%0d rsps=%0d required %0d", gq.size(), rq.size(), N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (i >= gq.size() || i >= rq.size() || gq[i] != i || rq[i] != i || dq[i] !== W'(3 * (i + 1)))
        begin failures++; $display("FAIL all_four_%0d grant=%0d rsp=%0d data=%0d required %0d/%0d/%0d", i, gq[i], rq[i], dq[i], i, i, 3 * (i + 1)); end
    end
  endtask

  task automatic test_fairness();
    int gq[$];
    logic [W-1:0] dq[$];
    bit r3_started = 1'b0;
    bus.req_a[1*W +: W] = 32'd5;
    bus.req_b[1*W +: W] = 32'd9;
    bus.req_a[3*W +: W] = 32'd11;
    bus.req_b[3*W +: W] = 32'd13;
    bus.req[1] = 1'b1;
    for (int t = 0; t < 300 && dq.size() < 3; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) gq.push_back(i);
        if (bus.rsp_valid[i]) dq.push_back(bus.rsp_data);
      end
      if (bus.gnt[1] && !r3_started) begin bus.req[3] = 1'b1; r3_started = 1'b1; end
      if (bus.gnt[3]) bus.req[3] = 1'b0;
      if (gq.size() >= 3) bus.req[1] = 1'b0;
    end
    checks++;
    if (gq.size() < 3 || dq.size() < 3 || gq[0] != 1 || gq[1] != 3 || gq[2] != 1)
      begin failures++; $display("FAIL fairness_order grants=%0d,%0d,%0d required 1,3,1", gq[0], gq[1], gq[2]); end
    checks++;
    if (dq[0] !== 32'd45 || dq[1] !== 32'd143 || dq[2] !== 32'd45)
      begin failures++; $display("FAIL fairness_data data=%0d,%0d,%0d required 45,143,45", dq[0], dq[1], dq[2]); end
    bus.req = '0;
    for (int t = 0; t < 60 && bus.busy; t++) step();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL fairness_drain busy=%b required 0", bus.busy); end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    bus.req_a[0 +: W] = 32'h0000_FFFF;
    bus.req_b[0 +: W] = 32'h0000_FFFF;
    bus.req[0] = 1'b1;
    step();
    bus.req[0] = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({obs, bus.rsp_data, bus.rsp_err, bus.m_mult0, bus.m_mult1} !== '0)
      begin failures++; $display("FAIL mid_reset_state obs=%h data=%h m0=%h m1=%h required all zero", obs, bus.rsp_data, bus.m_mult0, bus.m_mult1); end
    for (int t = 0; t < 25; t++) begin
      step();
      if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mid_reset_quiet active_cycles=%0d required 0", bad); end
    test_single_op("after_reset", 1, 32'h0000_FFFF, 32'h0000_FFFF, 17, 32'hFFFE_0001);
  endtask

  task automatic test_stuck_multiplier();
    logic [2*N+4:0] exp;
    stub_dead = 1'b1;
    bus.req_a[2*W +: W] = 32'd3;
    bus.req_b[2*W +: W] = 32'd5;
    bus.req[2] = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
    for (int t = 1; t <= TO + 6; t++) begin
      step();
      if (t == 1) bus.req[2] = 1'b0;
      exp = {(t == 1) ? 4'b0100 : 4'b0000, (t == TO + 2) ? 4'b0100 : 4'b0000,
             (t == 1) ? 4'd2 : 4'd0, (t <= TO + 2)};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL timeout t=%0d obs=%h required %h", t, obs, exp); end
      if (t == TO + 2) begin
        checks++;
        if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 32'd0})
          begin failures++; $display("FAIL timeout_data err=%b data=%h required 1/0", bus.rsp_err, bus.rsp_data); end
      end
      extra_done = (t == TO + 3);
    end
`else
    for (int t = 1; t <= 60; t++) begin
      step();
      if (t == 1) bus.req[2] = 1'b0;
      exp = {(t == 1) ? 4'b0100 : 4'b0000, 4'b0000, (t == 1) ? 4'd2 : 4'd0, 1'b1};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL stuck_hold t=%0d obs=%h required %h", t, obs, exp); end
    end
    extra_done = 1'b1;
    step();
    extra_done = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {4'b0100, 1'b0, 32'd15})
      begin failures++; $display("FAIL stuck_release rv=%b err=%b data=%0d required 0100/0/15", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL stuck_idle busy=%b required 0", bus.busy); end
`endif
    extra_done = 1'b0;
    stub_dead  = 1'b0;
  endtask

  // Transaction-level reference: each op occupies cycles [start, start+3+k).
  task automatic test_random();
    int g_cyc, r_cyc, idle_from, g_idx, rr, k;
    logic [W-1:0]   av [N];
    logic [W-1:0]   bv [N];
    logic [W-1:0]   r_data;
    logic [N-1:0]   oh;
    logic [2*N+4:0] exp;
    do_reset();
    g_cyc = -1; r_cyc = -1; idle_from = 0; g_idx = 0; rr = 0; r_data = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      oh = '0;
      oh[g_idx] = 1'b1;
      exp = {(cyc == g_cyc) ? oh : 4'b0000, (cyc == r_cyc) ? oh : 4'b0000,
             (cyc == g_cyc) ? 4'd2 : 4'd0, (cyc >= g_cyc && cyc < idle_from)};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL random cyc=%0d obs=%h required %h", cyc, obs, exp); end
      if (cyc == r_cyc) begin
        checks++;
        if ({bus.rsp_err, bus.rsp_data} !== {1'b0, r_data})
          begin failures++; $display("FAIL random_data cyc=%0d data=%h required %h", cyc, bus.rsp_data, r_data); end
      end
      if (cyc == g_cyc) bus.req[g_idx] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
          av[i] = $urandom;
          bv[i] = $urandom >> $urandom_range(32, 0);
          bus.req_a[i*W +: W] = av[i];
          bus.req_b[i*W +: W] = bv[i];
          bus.req[i] = 1'b1;
        end
      end
      if (cyc >= idle_from && bus.req != '0) begin
        for (int j = 0; j < N; j++) begin
          if (bus.req[(rr + j) % N]) begin g_idx = (rr + j) % N; break; end
        end
        rr        = (g_idx + 1) % N;
        k         = kof(bv[g_idx]);
        g_cyc     = cyc + 1;
        r_cyc     = cyc + 2 + k;
        idle_from = cyc + 3 + k;
        r_data    = av[g_idx] * bv[g_idx];
      end
      step();
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;
    stub_dead  = 1'b0;
    extra_done = 1'b0;
    test_reset();
    test_single_op("single", 0, 32'd6, 32'd7, 4, 32'd42);
    test_single_op("zero_operand", 2, 32'h0000_1234, 32'd0, 1, 32'd0);
    test_stray_done();
    test_all_four();
    test_fairness();
    test_reset_mid_wait();
    test_stuck_multiplier();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
